// File: rtl/fault_event_arbiter.sv
// Round-robin fault/event arbiter feeding an in-order FIFO, with a sticky halt flag.
// Optional macro FAULT_TIMESTAMP_EN adds a free-running timestamp captured per entry.
module fault_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int CODE_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TS_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*CODE_W-1:0]   src_code,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(NUM_SRC)-1:0]  out_src,
  output logic [CODE_W-1:0]           out_code,
  output logic [TS_W-1:0]             out_ts,
  output logic                        halt,
  input  logic                        clear_halt,
  output logic [7:0]                  stall_cnt
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(DEPTH);

  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q, count_d;
  logic               halt_q;
  logic [7:0]         stall_q;

  logic [SRC_W-1:0]   src_mem_q  [DEPTH];
  logic [CODE_W-1:0]  code_mem_q [DEPTH];

  logic               pop, can_push, push, found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W:0]     sum;
  logic [NUM_SRC-1:0] grant;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign can_push  = (count_q < (PTR_W+1)'(DEPTH)) || pop;

  // Search upward from rr_ptr; sum is one bit wider so the wrap needs no modulo.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    grant     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum = {1'b0, rr_ptr_q} + (SRC_W+1)'(k);
      if (sum >= (SRC_W+1)'(NUM_SRC)) sum = sum - (SRC_W+1)'(NUM_SRC);
      if (!found && src_valid[sum[SRC_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = sum[SRC_W-1:0];
      end
    end
    push = found && can_push && !rst;
    if (push) grant[grant_idx] = 1'b1;
  end

  assign src_ready = grant;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = (grant_idx == SRC_W'(NUM_SRC-1)) ? '0 : grant_idx + SRC_W'(1);
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
      stall_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      // A new fault outranks a simultaneous clear.
      if (push)            halt_q <= 1'b1;
      else if (clear_halt) halt_q <= 1'b0;
      if (|src_valid && !can_push && stall_q != 8'hFF) stall_q <= stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem_q[wr_ptr_q]  <= grant_idx;
      code_mem_q[wr_ptr_q] <= src_code[grant_idx*CODE_W +: CODE_W];
    end
  end

  assign out_src   = src_mem_q[rd_ptr_q];
  assign out_code  = code_mem_q[rd_ptr_q];
  assign halt      = halt_q;
  assign stall_cnt = stall_q;

`ifdef FAULT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem_q[wr_ptr_q] <= ts_q;
  end

  assign out_ts = ts_mem_q[rd_ptr_q];
`else
  assign out_ts = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(src_ready)) else $error("src_ready not one-hot-or-zero");
      assert ((src_ready & ~src_valid) == '0) else $error("src_ready without src_valid");
      assert (!$isunknown(out_valid)) else $error("out_valid is X");
      assert (!$isunknown(halt)) else $error("halt is X");
    end
  end
`endif

endmodule

// File: tb/tb_fault_event_arbiter.sv
// Randomized bench for fault_event_arbiter against a queue-based reference model.
module tb_fault_event_arbiter;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int D  = 4;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  src_valid = '0;
  logic [N*CW-1:0] src_code = '0;
  logic [N-1:0]  src_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_src;
  logic [CW-1:0] out_code;
  logic [TW-1:0] out_ts;
  logic          halt;
  logic          clear_halt = 1'b0;
  logic [7:0]    stall_cnt;

  fault_event_arbiter #(.NUM_SRC(N), .CODE_W(CW), .DEPTH(D), .TS_W(TW)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_code(src_code),
    .src_ready(src_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_code(out_code), .out_ts(out_ts),
    .halt(halt), .clear_halt(clear_halt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int src; int code; int ts; } ent_t;
  ent_t q[$];
  int rr, m_halt, m_stall, m_ts;
  int last_g;
  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_can();
    return (q.size() < D) || (q.size() > 0 && out_ready);
  endfunction

  function automatic int model_grant();
    if (rst || !model_can()) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if (src_valid[i]) return i;
    end
    return -1;
  endfunction

  // Inputs are set before the call (away from the edge); compare, then clock the model.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    bit can;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("src_ready", 64'(src_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("halt", 64'(halt), 64'(m_halt));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (q.size() > 0) begin
      chk("out_src", 64'(out_src), 64'(q[0].src));
      chk("out_code", 64'(out_code), 64'(q[0].code));
`ifdef FAULT_TIMESTAMP_EN
      chk("out_ts", 64'(out_ts), 64'(q[0].ts));
`else
      chk("out_ts", 64'(out_ts), 64'd0);
`endif
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      rr = 0; m_halt = 0; m_stall = 0; m_ts = 0;
    end else begin
      can = model_can();
      if (|src_valid && !can && m_stall < 255) m_stall++;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, int'(src_code[g*CW +: CW]), m_ts});
        rr = (g + 1) % N;
        m_halt = 1;
      end else if (clear_halt) begin
        m_halt = 0;
      end
      m_ts = (m_ts + 1) % (1 << TW);
    end
    last_g = g;
    @(negedge clk);
  endtask

  // Accepted (or idle) sources may raise a new request; pending ones hold.
  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      if (i == last_g || !src_valid[i]) begin
        if ($urandom_range(0, 2) != 0) begin
          src_valid[i] = 1'b1;
          src_code[i*CW +: CW] = CW'($urandom);
        end else begin
          src_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; src_valid = '0; out_ready = 1'b0; clear_halt = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rr = 0; m_halt = 0; m_stall = 0; m_ts = 0; last_g = -1;
    // First edge brings the DUT out of its unknown power-up state.
    src_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    cycle();
    do_reset();

    // Single event from source 2
    src_valid = 4'b0100; src_code[2*CW +: CW] = 8'h5A;
    cycle();
    src_valid = '0;
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    // Round robin with all sources asserting
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) src_code[i*CW +: CW] = CW'(16 * i + c);
      src_valid = 4'b1111;
      cycle();
    end

    // Fill with source 1 only, then stall
    do_reset();
    out_ready = 1'b0;
    src_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      src_code[1*CW +: CW] = CW'(8'hA0 + c);
      cycle();
    end
    // Push and pop in the same cycle while full
    src_valid = 4'b1000; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      src_code[3*CW +: CW] = CW'(8'hC0 + c);
      cycle();
    end

    // halt clear alone, then clear coinciding with an accept
    src_valid = '0;
    for (int c = 0; c < 6; c++) cycle();
    clear_halt = 1'b1;
    cycle();
    cycle();
    src_valid = 4'b0001; src_code[0 +: CW] = 8'h11;
    cycle();
    clear_halt = 1'b0; src_valid = '0;
    cycle();

    // Timestamp of an accept ten cycles after reset release
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) cycle();
    src_valid = 4'b0001; src_code[0 +: CW] = 8'h77;
    cycle();
    src_valid = '0;
    cycle();

    // Stall counter saturation
    do_reset();
    src_valid = 4'b1111;
    for (int c = 0; c < 270; c++) cycle();

    // Randomized traffic with occasional mid-run reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      out_ready  = ($urandom_range(0, 1) == 0);
      clear_halt = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      cycle();
      refresh();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fault_event_arbiter.md
Name: fault_event_arbiter

Overview:
- Collects runtime fault/assertion events raised by NUM_SRC GPU units (core, mem controller, etc.).
- Round-robin arbitrates them into a small in-order FIFO that is drained by the debug/host reader.
- Drives a sticky halt line so the rest of the design stops on the first fault.
- Synthesizable counterpart to the simulation-only fatal checks.

Parameters:
- NUM_SRC, 4: number of event sources; must be >= 2.
- CODE_W, 8: width of each source's fault code.
- DEPTH, 4: FIFO entries; must be a power of two, >= 2.
- TS_W, 16: timestamp width; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- src_valid  input  NUM_SRC  per-source event request. Held until accepted.
- src_code  input  NUM_SRC*CODE_W  packed codes. Source i occupies bits [i*CODE_W +: CODE_W].
- src_ready  output  NUM_SRC  one-hot-or-zero grant. Combinational.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  reader accepts the head entry.
- out_src  output  $clog2(NUM_SRC)  source index of the head entry.
- out_code  output  CODE_W  code of the head entry.
- out_ts  output  TS_W  timestamp of the head entry.
- halt  output  1  sticky fault-seen flag.
- clear_halt  input  1  clears halt.
- stall_cnt  output  8  saturating count of cycles in which a source was refused because the FIFO was full.

Behaviour:
- Reset values: rr_ptr=0, count=0, rd/wr pointers=0, halt=0, stall_cnt=0, timestamp counter=0. Consequently out_valid=0 and src_ready=0 after reset.
- Handshake: a source transfer happens when src_valid[i] && src_ready[i]. A source must hold src_valid and src_code stable until accepted. A reader transfer happens when out_valid && out_ready.
- Pop: pop = out_valid && out_ready.
- can_push: (count < DEPTH) || pop. Simultaneous push and pop when full is allowed.
- Grant:
  - If can_push, grant the first asserted src_valid found by searching upward from rr_ptr, wrapping modulo NUM_SRC.
  - At most one grant per cycle. src_ready is 0 for all sources if !can_push or no source is valid.
- Pointer update: on a grant to index g, rr_ptr <= (g+1) mod NUM_SRC. With no grant, rr_ptr holds.
- Fairness: a continuously requesting source is granted within NUM_SRC grants.
- Push: writes {g, src_code[g], ts} at wr_ptr; wr_ptr increments and wraps at DEPTH.
- Latency: an accepted event appears at out_* on the next cycle at the earliest (1-cycle latency, registered FIFO).
- Order: FIFO output order equals acceptance order.
- Read side: out_* reflect the entry at rd_ptr; rd_ptr advances on pop. out_* values are don't-care when out_valid=0.
- Count: count += push - pop. Never exceeds DEPTH, never underflows.
- halt:
  - Set to 1 the cycle after any push.
  - clear_halt clears it on the next cycle.
  - If clear_halt coincides with a push, set wins.
  - halt does not affect arbitration.
- stall_cnt: increments when |src_valid && !can_push. Saturates at 255. Cleared only by rst.
- Reset mid-operation: any in-flight push or pop is discarded and FIFO contents are lost. No grant is issued in the reset cycle.
- Invariants, checked with simulation assertions:
  - src_ready is one-hot or zero.
  - src_ready[i] implies src_valid[i].
  - No X on out_valid or halt when out of reset.

Optional Feature:
- Macro: FAULT_TIMESTAMP_EN.
- Defined: a free-running TS_W cycle counter increments every cycle from reset 0 and wraps at 2^TS_W. Each entry captures the counter value in its acceptance cycle, presented on out_ts.
- Undefined: no counter and no timestamp storage; out_ts is tied to 0. The port list is unchanged.

Test Plan:
- Single event: after reset, src_valid=4'b0100, code 0x5A for 1 cycle -> src_ready=4'b0100 that cycle. Next cycle: out_valid=1, out_src=2, out_code=0x5A, halt=1.
- Round-robin: all four sources valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1. The FIFO never fills and stall_cnt stays 0.
- Full/stall: out_ready=0, src 1 valid for 6 cycles -> 4 accepts (DEPTH), then src_ready=0. stall_cnt=2 after the 6 cycles, and out_* shows the first entry unchanged.
- Push+pop at full: FIFO full, out_ready=1, src 3 valid -> same-cycle grant and pop, count stays 4, order preserved.
- halt precedence: clear_halt=1 with no event -> halt=0 next cycle. clear_halt=1 coinciding with an accept -> halt stays 1.
- Timestamp (macro defined): event accepted 10 cycles after reset release -> out_ts=10. With the macro undefined, out_ts=0.
